dp_rr_scheduler: RTL and testbench
==================================

// Module: dp_rr_scheduler
// PURPOSE
// - Shares one compute datapath (the input_valid/output_valid unit of Experiment 1) between N_REQ requesters.
// - Round-robin arbitration; one job in flight at a time.
// - Drives the datapath start strobe, waits for its completion strobe, then returns a done pulse to the granted requester.
// - Sits between the requester front-ends and the datapath controller; owns only sequencing, no data.
// PARAMETERS
// N_REQ        4    number of requesters (2..8)
// ID_W         2    width of cur_id; equals $clog2(N_REQ)
// TIMEOUT_CYC  16   watchdog limit in cycles spent in WAIT (only used with SCHED_WATCHDOG_EN)
// PORTS
// clk        in   1       single clock; everything updates on posedge
// rst        in   1       synchronous, active-low reset (sampled on posedge clk)
// req        in   N_REQ   level request per requester; held until its done/err pulse
// gnt        out  N_REQ   one-hot grant; held from GRANT through RELEASE/ABORT
// cur_id     out  ID_W    index of the granted requester; 0 when idle
// busy       out  1       high in any state other than IDLE
// dp_start   out  1       1-cycle start pulse to datapath (its input_valid)
// dp_done    in   1       1-cycle completion pulse from datapath (its output_valid)
// dp_abort   out  1       1-cycle datapath clear on watchdog expiry
// done       out  N_REQ   1-cycle one-hot completion pulse to the granted requester
// err        out  N_REQ   1-cycle one-hot timeout pulse to the granted requester
// BEHAVIOUR
// - Reset (rst==0 at a posedge): state=IDLE, last_ptr=N_REQ-1, watchdog=0.
//   All outputs 0 (gnt, cur_id, busy, dp_start, dp_abort, done, err).
//   Reset mid-job abandons the job silently; no done/err pulse.
// - Registered FSM; outputs decoded from state + registered grant (Moore, glitch-free).
// - IDLE: if |req, pick the first asserted req scanning last_ptr+1, last_ptr+2, ... (mod N_REQ).
//   Latch the one-hot grant and go to GRANT. Otherwise stay in IDLE.
// - GRANT (1 cycle): gnt/cur_id/busy valid -> START.
// - START (1 cycle): dp_start=1 -> WAIT.
// - WAIT: stay until dp_done==1 -> RELEASE.
// - RELEASE (1 cycle): done[cur_id]=1; last_ptr<=cur_id -> IDLE.
// - ABORT (1 cycle, watchdog only): dp_abort=1, err[cur_id]=1; last_ptr<=cur_id -> IDLE.
// - Latency: req high with FSM in IDLE at edge 0.
//   gnt after edge 1; dp_start during cycle after edge 2.
//   dp_done sampled at edge k gives done pulse during cycle after edge k.
//   Minimum per-job overhead: 4 cycles plus datapath time.
// - Back-to-back jobs: one IDLE cycle always separates RELEASE/ABORT from the next GRANT.
// - Fairness: a requester just served has lowest priority on the next pick.
//   With all req high, grants cycle 0,1,2,3,0,...
// - dp_done outside WAIT (IDLE/GRANT/START/RELEASE) is ignored.
// - req of the granted requester dropping mid-job is ignored; the job completes and done still pulses.
// - New or changed req while busy only affects the next IDLE pick.
// - At most one bit of gnt/done/err is ever high; done and err are never high together.
// CONFIGURATION
// - SCHED_WATCHDOG_EN defined:
//   - Watchdog counter clears on entering WAIT and increments each WAIT cycle.
//   - When it reaches TIMEOUT_CYC without dp_done -> ABORT.
//   - If dp_done and expiry coincide in the same cycle, dp_done wins (RELEASE, no err).
// - SCHED_WATCHDOG_EN not defined:
//   - No counter, no ABORT state; WAIT blocks until dp_done.
//   - dp_abort and err are tied to 0; the ports remain present.
// TESTING
// T1 reset: drive rst=0 for 2 cycles with req=4'b1111 -> all outputs 0; after release gnt=4'b0001 one cycle later.
// T2 single job: req=4'b0100, dp_done 3 cycles after dp_start -> gnt=0100, cur_id=2, busy high.
//    done=4'b0100 pulses once; busy low the cycle after.
// T3 round-robin: req=4'b1111 held for 5 jobs -> grant order 0,1,2,3,0; exactly one IDLE cycle between jobs.
// T4 mid-op events: drop granted req during WAIT -> done still pulses.
//    Stray dp_done in IDLE -> no response. rst=0 during WAIT -> IDLE, no done/err.
// T5 watchdog (macro on, TIMEOUT_CYC=16): dp_done never arrives -> after 16 WAIT cycles dp_abort=1 and err=gnt for 1 cycle.
//    Next pick skips the aborted requester.
// T6 watchdog race (macro on): dp_done in the 16th WAIT cycle -> done pulses, err and dp_abort stay 0.
//    Macro off: 100-cycle stall, no err, then dp_done -> done pulses.

Source files
------------

// File: rtl/dp_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dp_rr_scheduler
// Description : Round-robin job sequencer that shares one compute datapath
//               between N_REQ requesters. Only one job is in flight at a
//               time. The block owns the sequencing only and carries no data.
//               For each job it grants one requester, pulses dp_start, waits
//               for dp_done, and then returns a one-cycle done pulse to the
//               granted requester.
// Ports       : clk       - clock; all state updates on posedge
//               rst       - synchronous reset, active low
//               req       - level request per requester
//               gnt       - one-hot grant, held GRANT..RELEASE/ABORT
//               cur_id    - index of the granted requester (0 when idle)
//               busy      - high in every state except IDLE
//               dp_start  - 1-cycle start strobe to the datapath
//               dp_done   - 1-cycle completion strobe from the datapath
//               dp_abort  - 1-cycle datapath clear on watchdog expiry
//               done      - 1-cycle one-hot completion pulse
//               err       - 1-cycle one-hot timeout pulse
// Config      : define SCHED_WATCHDOG_EN to enable the WAIT watchdog and the
//               ABORT path. When it is undefined, dp_abort and err are
//               tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module dp_rr_scheduler #(
    parameter int N_REQ       = 4,
    parameter int ID_W        = 2,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  cur_id,
    output logic             busy,
    output logic             dp_start,
    input  logic             dp_done,
    output logic             dp_abort,
    output logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_GRANT   = 3'd1;
    localparam logic [2:0] S_START   = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;
    localparam logic [2:0] S_ABORT   = 3'd5;

    // Parameter sanity is checked at elaboration time.
    if (N_REQ < 2 || N_REQ > 8 || ID_W != $clog2(N_REQ) || TIMEOUT_CYC < 1) begin : g_param_check
        $error("dp_rr_scheduler: illegal parameter combination");
    end

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [N_REQ-1:0] r_gnt;
    logic [ID_W-1:0]  r_id;
    logic [ID_W-1:0]  r_last_ptr;
    logic             w_pick_found;
    logic [ID_W-1:0]  w_pick_id;
    logic [ID_W-1:0]  w_cand;
    logic             w_wd_expire;

    // Round-robin pick. Candidates are scanned from the farthest offset down
    // to the nearest one, so the last hit is the requester closest after
    // r_last_ptr. The requester served last is therefore considered last.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_id    = '0;
        w_cand       = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_cand = ID_W'((int'(r_last_ptr) + k) % N_REQ);
            if (req[w_cand]) begin
                w_pick_found = 1'b1;
                w_pick_id    = w_cand;
            end
        end
    end

    // Next-state logic. In WAIT, dp_done is tested ahead of the watchdog, so
    // a completion that arrives in the expiry cycle still completes normally.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_pick_found) w_state_nxt = S_GRANT;
            S_GRANT:   w_state_nxt = S_START;
            S_START:   w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (dp_done)          w_state_nxt = S_RELEASE;
                else if (w_wd_expire) w_state_nxt = S_ABORT;
            end
            S_RELEASE: w_state_nxt = S_IDLE;
            S_ABORT:   w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The grant is latched once in IDLE. It stays stable for the whole job,
    // so later req changes only affect the next pick.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_gnt      <= '0;
            r_id       <= '0;
            r_last_ptr <= ID_W'(N_REQ - 1);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_found) begin
                        r_gnt <= N_REQ'(1) << w_pick_id;
                        r_id  <= w_pick_id;
                    end
                end
                S_RELEASE, S_ABORT: begin
                    r_last_ptr <= r_id;
                    r_gnt      <= '0;
                    r_id       <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] r_wd;

    // The counter is cleared in START, so it holds 0 in the first WAIT
    // cycle. Expiry is flagged in WAIT cycle TIMEOUT_CYC.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wd <= '0;
        end else if (r_state == S_START) begin
            r_wd <= '0;
        end else if (r_state == S_WAIT) begin
            r_wd <= r_wd + WD_W'(1);
        end
    end

    assign w_wd_expire = (r_state == S_WAIT) && (r_wd == WD_W'(TIMEOUT_CYC - 1));
    assign dp_abort    = (r_state == S_ABORT);
    assign err         = (r_state == S_ABORT) ? r_gnt : '0;
`else
    assign w_wd_expire = 1'b0;
    assign dp_abort    = 1'b0;
    assign err         = '0;
`endif

    // All outputs are decoded from registered state only.
    assign gnt      = r_gnt;
    assign cur_id   = r_id;
    assign busy     = (r_state != S_IDLE);
    assign dp_start = (r_state == S_START);
    assign done     = (r_state == S_RELEASE) ? r_gnt : '0;

endmodule
`default_nettype wire

// File: tb/tb_dp_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_dp_rr_scheduler
// Description : Directed self-checking bench for dp_rr_scheduler. Inputs are
//               driven, and outputs sampled, 1 time unit after each rising
//               clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dp_rr_scheduler;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  cur_id;
    logic             busy;
    logic             dp_start;
    logic             dp_done;
    logic             dp_abort;
    logic [N_REQ-1:0] done;
    logic [N_REQ-1:0] err;

    int n_checks = 0;
    int n_fail   = 0;

    dp_rr_scheduler #(
        .N_REQ       (N_REQ),
        .ID_W        (ID_W),
        .TIMEOUT_CYC (16)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .gnt      (gnt),
        .cur_id   (cur_id),
        .busy     (busy),
        .dp_start (dp_start),
        .dp_done  (dp_done),
        .dp_abort (dp_abort),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        check(tag, {15'd0, gnt, cur_id, busy, dp_start, dp_abort, done, err}, 32'd0);
    endtask

    // Runs one job. On entry the FSM is in IDLE and req is already driven.
    // dp_done is raised during WAIT cycle number dly (1-based). If drop is
    // set, every request is withdrawn in the first WAIT cycle.
    task automatic run_job(input logic [N_REQ-1:0] exp_gnt, input int exp_id,
                           input int dly, input bit drop);
        tick;
        check("grant_gnt", gnt, exp_gnt);
        check("grant_id", cur_id, exp_id);
        check("grant_ctl", {busy, dp_start, (done != '0)}, 3'b100);
        tick;
        check("start", {gnt, busy, dp_start}, {exp_gnt, 2'b11});
        tick;
        if (drop) req = '0;
        check("wait_enter", {busy, dp_start}, 2'b10);
        for (int i = 1; i < dly; i++) begin
            tick;
            check("wait_hold", {busy, dp_start, dp_abort, err, done}, 11'b100_0000_0000);
        end
        dp_done = 1'b1;
        tick;
        dp_done = 1'b0;
        check("release_done", done, exp_gnt);
        check("release_err", {dp_abort, err}, 5'd0);
        check("release_gnt", gnt, exp_gnt);
        tick;
        check("post_idle", {busy, gnt, done}, 9'd0);
    endtask

    // Expected grant order after reset with all requests held high.
    int c_rr_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        #100000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst     = 1'b0;
        req     = 4'b1111;
        dp_done = 1'b0;

        // T1: reset held for two cycles with every requester asserted.
        tick;
        tick;
        chk_idle("reset_outs");
        rst = 1'b1;
        run_job(4'b0001, 0, 2, 1'b0);
        req = '0;

        // T2: single job for requester 2, done three cycles after dp_start.
        req = 4'b0100;
        run_job(4'b0100, 2, 3, 1'b0);
        req = '0;

        // T3: round-robin from reset with all requests held.
        rst = 1'b0;
        tick;
        rst = 1'b1;
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            run_job(4'(1 << c_rr_order[j]), c_rr_order[j], j + 1, 1'b0);
        end
        req = '0;

        // T4a: granted request dropped in WAIT; the job still completes.
        req = 4'b0010;
        run_job(4'b0010, 1, 2, 1'b1);

        // T4b: a stray dp_done in IDLE gets no response.
        dp_done = 1'b1;
        tick;
        dp_done = 1'b0;
        check("stray_done", {busy, gnt, done, err}, 13'd0);
        tick;
        check("stray_after", {busy, gnt, done, err}, 13'd0);

        // T4c: reset in WAIT abandons the job silently.
        req = 4'b1000;
        tick;
        check("rstwait_gnt", gnt, 4'b1000);
        tick;
        tick;
        check("rstwait_busy", {busy, dp_start}, 2'b10);
        rst = 1'b0;
        req = '0;
        tick;
        chk_idle("rstwait_reset");
        rst     = 1'b1;
        dp_done = 1'b1;
        tick;
        dp_done = 1'b0;
        chk_idle("rstwait_after");

`ifdef SCHED_WATCHDOG_EN
        // T5: dp_done never arrives, so the watchdog aborts after 16 WAIT cycles.
        req = 4'b0001;
        tick;
        check("wd_gnt", gnt, 4'b0001);
        tick;
        tick;
        for (int i = 1; i < 16; i++) begin
            tick;
            check("wd_wait", {busy, dp_abort, err, done}, 10'b10_0000_0000);
        end
        tick;
        check("wd_abort", {dp_abort, err, done}, 9'b1_0001_0000);
        check("wd_abort_gnt", gnt, 4'b0001);
        req = 4'b0011;
        tick;
        chk_idle("wd_post_idle");
        run_job(4'b0010, 1, 4, 1'b0);
        req = '0;

        // T6: dp_done in the 16th WAIT cycle wins over expiry.
        req = 4'b0100;
        run_job(4'b0100, 2, 16, 1'b0);
        req = '0;
`else
        // T6 (no watchdog): a 100-cycle stall, then completion.
        req = 4'b0100;
        run_job(4'b0100, 2, 101, 1'b0);
        req = '0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
